bp_inflight_queue: RTL and testbench
====================================

// Module: bp_inflight_queue
// PURPOSE
// - Sits between IF-stage branch prediction and EX-stage branch resolution.
// - Records every predicted branch in order at fetch: PC, predicted direction, predicted target, predictor meta bits.
// - Pops the oldest entry when EX resolves a branch.
// - Detects mispredicts, drives predictor-table training (upd_valid/upd_taken/upd_waddr) and the front-end redirect.
// PARAMETERS
// - DEPTH   4   in-flight branch entries; power of two, >=2
// - META_W  4   per-entry predictor meta (component predictions) returned at training
// PORTS
// - clk             in   1       clock
// - rst             in   1       synchronous active-high reset
// - load_stall      in   1       pipeline freeze: no push, pop, flush or training this cycle
// - push            in   1       IF issues a predicted branch
// - push_pc         in   32      PC of that branch
// - push_pred       in   1       predicted taken
// - push_target     in   32      predicted target (don't-care when push_pred=0)
// - push_meta       in   META_W  predictor meta at prediction time
// - full            out  1       count==DEPTH (combinational from count)
// - count           out  $clog2(DEPTH)+1  occupied entries
// - resolve_valid   in   1       EX resolves the oldest in-flight branch
// - resolve_taken   in   1       actual direction
// - resolve_target  in   32      actual taken target
// - ext_flush       in   1       external squash (trap/jump); empties queue
// - upd_valid       out  1       train predictor this cycle
// - upd_taken       out  1       actual outcome to train
// - upd_waddr       out  32      PC of the trained branch
// - upd_meta        out  META_W  meta of the trained branch
// - mispredict      out  1       1-cycle pulse: redirect front end
// - redirect_pc     out  32      resolve_taken ? resolve_target : pc+4
// - err_overflow    out  1       sticky: push dropped because full
// - err_underflow   out  1       sticky: resolve while empty
// BEHAVIOUR
// - Reset: rd/wr pointers=0, count=0; all outputs 0, including sticky errors. Entries need not be cleared.
// - Circular buffer with wrap-around pointers.
// - Effective strobes: eff_push = push & ~load_stall; eff_pop = resolve_valid & ~load_stall & count!=0.
// - Push while full:
//   - accepted if eff_pop fires the same cycle (the pop frees a slot);
//   - otherwise dropped and err_overflow set.
// - resolve_valid & ~load_stall & count==0: ignored, err_underflow set, no training.
// - Training, registered, 1-cycle latency: on cycle N eff_pop -> on N+1
//   - upd_valid=1;
//   - upd_taken=resolve_taken;
//   - upd_waddr=entry.pc;
//   - upd_meta=entry.meta.
// - Mispredict on eff_pop when:
//   - entry.pred != resolve_taken, or
//   - both taken and entry.target != resolve_target.
//   Response on N+1: mispredict=1 and redirect_pc valid. mispredict and redirect_pc are 0 whenever upd_valid=0.
// - Mispredict or ext_flush (when ~load_stall) empties the queue at the clock edge:
//   - count=0, rd=wr;
//   - any same-cycle push is discarded (wrong path), not counted as overflow.
// - ext_flush with load_stall=1 is deferred; the source holds it until the stall drops.
// - load_stall=1: state frozen, upd_valid and mispredict drive 0 next cycle.
// - pc+4 is computed modulo 2^32.
// TESTING
// - Reset, push 3 (pc 0x100/0x104/0x108, pred 1/0/1) -> count=3, full=0, no upd_valid.
// - Resolve those 3 in order, all correct -> upd_waddr 0x100,0x104,0x108 each 1 cycle later; mispredict never 1.
// - Resolve pc 0x104 pred 0 with taken=1, target 0x200, plus same-cycle push -> next cycle mispredict=1, redirect_pc=0x200, count=0.
// - Fill DEPTH=4; push+resolve same cycle -> count stays 4, no err_overflow; push alone -> dropped, err_overflow=1.
// - Taken/taken target mismatch (pred 0x300, actual 0x340) -> mispredict=1, redirect_pc=0x340.
// - Resolve with load_stall=1 -> no pop, upd_valid=0; assert rst mid-fill -> count=0, all outputs 0.

Source files
------------

// File: rtl/bp_inflight_queue.sv
// bp_inflight_queue: ordered record of predicted branches between fetch and execute.
// Each resolve pops the oldest entry, trains the predictor one cycle later, and
// raises a redirect when the stored prediction disagrees with the actual outcome.
module bp_inflight_queue #(
   parameter int DEPTH  = 4,
   parameter int META_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_stall,
   input  logic                     push,
   input  logic [31:0]              push_pc,
   input  logic                     push_pred,
   input  logic [31:0]              push_target,
   input  logic [META_W-1:0]        push_meta,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   input  logic [31:0]              resolve_target,
   input  logic                     ext_flush,
   output logic                     upd_valid,
   output logic                     upd_taken,
   output logic [31:0]              upd_waddr,
   output logic [META_W-1:0]        upd_meta,
   output logic                     mispredict,
   output logic [31:0]              redirect_pc,
   output logic                     err_overflow,
   output logic                     err_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Sequential fall-through address; wraps modulo 2^32 by width.
   function automatic logic [31:0] f_fallthrough(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Entry storage (data only, never reset)
   logic [31:0]       r_pc   [DEPTH];
   logic              r_pred [DEPTH];
   logic [31:0]       r_tgt  [DEPTH];
   logic [META_W-1:0] r_meta [DEPTH];

   // Control state
   logic [PW-1:0]     r_rd;
   logic [PW-1:0]     r_wr;
   logic [CW-1:0]     r_count;
   logic              r_err_ovf;
   logic              r_err_udf;

   // Training / redirect response registers
   logic              r_upd_valid_p1;
   logic              r_upd_taken_p1;
   logic [31:0]       r_upd_waddr_p1;
   logic [META_W-1:0] r_upd_meta_p1;
   logic              r_mis_p1;
   logic [31:0]       r_redirect_p1;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_underflow;
   logic              w_push_req;
   logic              w_push_ok;
   logic              w_overflow;
   logic              w_flush;
   logic              w_mis;
   logic              w_dir_miss;
   logic              w_tgt_miss;
   logic [31:0]       w_head_pc;
   logic              w_head_pred;
   logic [31:0]       w_head_tgt;
   logic [META_W-1:0] w_head_meta;
   logic [31:0]       w_redirect;
   logic [CW-1:0]     w_inc;
   logic [CW-1:0]     w_dec;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_pop       = resolve_valid & ~load_stall & ~w_empty;
   assign w_underflow = resolve_valid & ~load_stall & w_empty;

   assign w_head_pc   = r_pc[r_rd];
   assign w_head_pred = r_pred[r_rd];
   assign w_head_tgt  = r_tgt[r_rd];
   assign w_head_meta = r_meta[r_rd];

   // A wrong direction, or a correct taken guess to the wrong place, both redirect.
   assign w_dir_miss  = w_head_pred ^ resolve_taken;
   assign w_tgt_miss  = w_head_pred & resolve_taken & (w_head_tgt != resolve_target);
   assign w_mis       = w_pop & (w_dir_miss | w_tgt_miss);
   assign w_redirect  = resolve_taken ? resolve_target : f_fallthrough(w_head_pc);

   // A flush makes any same-cycle push wrong-path: it is dropped silently.
   assign w_flush     = w_mis | (ext_flush & ~load_stall);
   assign w_push_req  = push & ~load_stall;
   assign w_push_ok   = w_push_req & ~w_flush & (~w_full | w_pop);
   assign w_overflow  = w_push_req & ~w_flush & w_full & ~w_pop;

   assign w_inc       = {{(CW-1){1'b0}}, w_push_ok};
   assign w_dec       = {{(CW-1){1'b0}}, w_pop};

   // Write accepted branches into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_pc[r_wr]   <= push_pc;
         r_pred[r_wr] <= push_pred;
         r_tgt[r_wr]  <= push_target;
         r_meta[r_wr] <= push_meta;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd      <= '0;
         r_wr      <= '0;
         r_count   <= '0;
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
      end else begin
         if (w_flush) begin
            r_rd    <= r_wr;
            r_count <= '0;
         end else begin
            if (w_pop) begin
               r_rd <= r_rd + 1'b1;
            end
            if (w_push_ok) begin
               r_wr <= r_wr + 1'b1;
            end
            r_count <= r_count + w_inc - w_dec;
         end
         if (w_overflow) begin
            r_err_ovf <= 1'b1;
         end
         if (w_underflow) begin
            r_err_udf <= 1'b1;
         end
      end
   end

   // ---- stage boundary: resolve (N) -> training/redirect response (N+1) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_upd_valid_p1 <= 1'b0;
         r_upd_taken_p1 <= 1'b0;
         r_upd_waddr_p1 <= '0;
         r_upd_meta_p1  <= '0;
         r_mis_p1       <= 1'b0;
         r_redirect_p1  <= '0;
      end else begin
         r_upd_valid_p1 <= w_pop;
         r_upd_taken_p1 <= w_pop & resolve_taken;
         r_upd_waddr_p1 <= w_pop ? w_head_pc : '0;
         r_upd_meta_p1  <= w_pop ? w_head_meta : '0;
         r_mis_p1       <= w_mis;
         r_redirect_p1  <= w_mis ? w_redirect : '0;
      end
   end

   assign full          = w_full;
   assign count         = r_count;
   assign upd_valid     = r_upd_valid_p1;
   assign upd_taken     = r_upd_taken_p1;
   assign upd_waddr     = r_upd_waddr_p1;
   assign upd_meta      = r_upd_meta_p1;
   assign mispredict    = r_mis_p1;
   assign redirect_pc   = r_redirect_p1;
   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_udf;

endmodule

// File: tb/tb_bp_inflight_queue.sv
// Bench for bp_inflight_queue: directed scenarios then random traffic, with a
// queue-based reference model and a scoreboard drained by a separate monitor.
module tb_bp_inflight_queue;

   localparam int DEPTH  = 4;
   localparam int META_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_stall = 1'b0;
   logic              push = 1'b0;
   logic [31:0]       push_pc = '0;
   logic              push_pred = 1'b0;
   logic [31:0]       push_target = '0;
   logic [META_W-1:0] push_meta = '0;
   logic              full;
   logic [2:0]        count;
   logic              resolve_valid = 1'b0;
   logic              resolve_taken = 1'b0;
   logic [31:0]       resolve_target = '0;
   logic              ext_flush = 1'b0;
   logic              upd_valid;
   logic              upd_taken;
   logic [31:0]       upd_waddr;
   logic [META_W-1:0] upd_meta;
   logic              mispredict;
   logic [31:0]       redirect_pc;
   logic              err_overflow;
   logic              err_underflow;

   bp_inflight_queue #(.DEPTH(DEPTH), .META_W(META_W)) dut (
      .clk(clk), .rst(rst), .load_stall(load_stall),
      .push(push), .push_pc(push_pc), .push_pred(push_pred),
      .push_target(push_target), .push_meta(push_meta),
      .full(full), .count(count),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target), .ext_flush(ext_flush),
      .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_waddr(upd_waddr),
      .upd_meta(upd_meta), .mispredict(mispredict), .redirect_pc(redirect_pc),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       pc;
      bit                pred;
      logic [31:0]       tgt;
      logic [META_W-1:0] meta;
   } ent_t;

   typedef struct {
      int                cyc;
      bit                taken;
      logic [31:0]       addr;
      logic [META_W-1:0] meta;
      bit                mis;
      logic [31:0]       redir;
   } exp_t;

   ent_t mq[$];
   exp_t eq[$];
   bit   m_eo = 1'b0;
   bit   m_eu = 1'b0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: apply one clock edge worth of inputs to the abstract queue.
   task automatic model_step(input bit r, input bit ls, input bit p, input logic [31:0] ppc,
                             input bit ppred, input logic [31:0] ptgt, input logic [META_W-1:0] pm,
                             input bit rv, input bit rt, input logic [31:0] rtgt, input bit fl);
      ent_t e;
      exp_t x;
      bit   mis;
      if (r) begin
         mq.delete();
         m_eo = 1'b0;
         m_eu = 1'b0;
         return;
      end
      if (ls) return;
      mis = 1'b0;
      if (rv) begin
         if (mq.size() == 0) begin
            m_eu = 1'b1;
         end else begin
            e = mq.pop_front();
            mis = (e.pred != rt) || (e.pred && rt && (e.tgt != rtgt));
            x.cyc   = cyc + 1;
            x.taken = rt;
            x.addr  = e.pc;
            x.meta  = e.meta;
            x.mis   = mis;
            x.redir = rt ? rtgt : (e.pc + 32'd4);
            eq.push_back(x);
         end
      end
      if (mis || fl) begin
         mq.delete();
      end else if (p) begin
         if (mq.size() < DEPTH) begin
            e.pc = ppc; e.pred = ppred; e.tgt = ptgt; e.meta = pm;
            mq.push_back(e);
         end else begin
            m_eo = 1'b1;
         end
      end
   endtask

   task automatic drive(input bit r, input bit ls, input bit p, input logic [31:0] ppc,
                        input bit ppred, input logic [31:0] ptgt, input logic [META_W-1:0] pm,
                        input bit rv, input bit rt, input logic [31:0] rtgt, input bit fl);
      @(negedge clk);
      #1;
      rst = r; load_stall = ls; push = p; push_pc = ppc; push_pred = ppred;
      push_target = ptgt; push_meta = pm; resolve_valid = rv; resolve_taken = rt;
      resolve_target = rtgt; ext_flush = fl;
      model_step(r, ls, p, ppc, ppred, ptgt, pm, rv, rt, rtgt, fl);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic do_push(input logic [31:0] pc, input bit pred, input logic [31:0] tgt,
                          input logic [META_W-1:0] m);
      drive(0, 0, 1, pc, pred, tgt, m, 0, 0, 0, 0);
   endtask
   task automatic do_res(input bit t, input logic [31:0] tgt);
      drive(0, 0, 0, 0, 0, 0, 0, 1, t, tgt, 0);
   endtask

   // Monitor: occupancy/errors every cycle, training responses from the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("count", 32'(count), 32'(mq.size()));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("err_overflow", 32'(err_overflow), 32'(m_eo));
         chk("err_underflow", 32'(err_underflow), 32'(m_eu));
         if (upd_valid === 1'b1) begin
            if (eq.size() == 0 || eq[0].cyc != cyc) begin
               checks++;
               errors++;
               $display("FAIL spurious_upd_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               e = eq.pop_front();
               chk("upd_taken", 32'(upd_taken), 32'(e.taken));
               chk("upd_waddr", upd_waddr, e.addr);
               chk("upd_meta", 32'(upd_meta), 32'(e.meta));
               chk("mispredict", 32'(mispredict), 32'(e.mis));
               if (e.mis) chk("redirect_pc", redirect_pc, e.redir);
            end
         end else begin
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
               e = eq.pop_front();
               checks++;
               errors++;
               $display("FAIL missing_upd_valid actual=%b expected=1 pc=%h (cycle %0d)",
                        upd_valid, e.addr, cyc);
            end
            chk("idle_mispredict", 32'(mispredict), 32'd0);
            chk("idle_redirect_pc", redirect_pc, 32'd0);
         end
      end
   end

   initial begin
      bit                r, ls, p, pp, rv, rt, fl;
      logic [31:0]       ppc, pt, rtg;
      logic [META_W-1:0] pm;

      // Reset, then push three predicted branches
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      idle();
      do_push(32'h100, 1, 32'h180, 4'h1);
      do_push(32'h104, 0, 32'h0,   4'h2);
      do_push(32'h108, 1, 32'h1A0, 4'h3);
      idle();

      // Resolve all three correctly
      do_res(1, 32'h180);
      do_res(0, 32'h0);
      do_res(1, 32'h1A0);
      idle();

      // Direction mispredict with a same-cycle wrong-path push
      do_push(32'h104, 0, 32'h0, 4'h5);
      drive(0, 0, 1, 32'h500, 1, 32'h600, 4'h6, 1, 1, 32'h200, 0);
      idle();

      // Fill, push+resolve while full, then push alone while full
      for (int i = 0; i < DEPTH; i++) do_push(32'h1000 + 32'(i * 4), 0, 32'h0, 4'(i));
      drive(0, 0, 1, 32'h2000, 0, 32'h0, 4'h9, 1, 0, 32'h0, 0);
      do_push(32'h3000, 0, 32'h0, 4'hA);
      idle();

      // External flush, then taken/taken target mismatch
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      do_push(32'h400, 1, 32'h300, 4'hB);
      do_res(1, 32'h340);
      idle();

      // Not-taken mispredict at the top of the address space: pc+4 wraps to 0
      do_push(32'hFFFF_FFFC, 1, 32'h10, 4'hC);
      do_res(0, 32'h0);
      idle();

      // Underflow: resolve while empty
      do_res(1, 32'h44);
      idle();

      // Resolve under load_stall, deferred flush, then reset mid-fill
      do_push(32'h700, 0, 32'h0, 4'h1);
      do_push(32'h704, 0, 32'h0, 4'h2);
      drive(0, 1, 1, 32'h708, 0, 32'h0, 4'h3, 1, 0, 32'h0, 1);
      idle();
      drive(1, 0, 1, 32'h70C, 0, 32'h0, 4'h4, 1, 0, 32'h0, 0);
      @(negedge clk);
      chk("rst_upd_valid", 32'(upd_valid), 32'd0);
      chk("rst_upd_taken", 32'(upd_taken), 32'd0);
      chk("rst_upd_waddr", upd_waddr, 32'd0);
      chk("rst_upd_meta", 32'(upd_meta), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      idle();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 299) == 0);
         ls  = ($urandom_range(0, 6) == 0);
         p   = $urandom_range(0, 1) == 1;
         ppc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) ppc = 32'hFFFF_FFFC;
         pp  = $urandom_range(0, 1) == 1;
         pt  = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
         pm  = 4'($urandom_range(0, 15));
         rv  = $urandom_range(0, 1) == 1;
         fl  = ($urandom_range(0, 49) == 0);
         if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
            rt  = mq[0].pred;
            rtg = mq[0].tgt;
         end else begin
            rt  = $urandom_range(0, 1) == 1;
            rtg = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
         end
         drive(r, ls, p, ppc, pp, pt, pm, rv, rt, rtg, fl);
      end

      idle();
      idle();
      @(negedge clk);
      chk("scoreboard_drained", 32'(eq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
